// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB camera init sequencer.
//   - state_t    : sequencer FSM states
//   - TBL_END    : table word terminating the register table
//   - TBL_DELAY  : table word requesting a long pause before the next entry
//   - OV2640_*   : SCCB write/read device IDs
//   - max_u      : helper used to size shared counters
package sccb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PWR,
    ST_WAKE,
    ST_FETCH,
    ST_LATCH,
    ST_ISSUE,
    ST_WAIT,
    ST_GAP,
    ST_DLY,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic [15:0] TBL_END   = 16'hFFFF;
  localparam logic [15:0] TBL_DELAY = 16'hFFFE;

  localparam logic [7:0] OV2640_WR_ID = 8'h60;
  localparam logic [7:0] OV2640_RD_ID = 8'h61;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sccb_delay_timer.sv
// Loadable down-counter shared by every timed phase of the sequencer.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   start    : load the counter with 'load' (phase entry)
//   load     : terminal distance, i.e. (cycles in phase - 1)
//   expired  : high while the count has reached zero
module sccb_delay_timer #(
  parameter int unsigned CW = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] load,
  output logic          expired
);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (start) begin
      count <= load;
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/sccb_init_sequencer.sv
// Camera register initialisation sequencer for an SCCB master core.
// Powers the sensor up via PWDN, then walks a {sub_addr, data} table held in
// an external synchronous ROM and issues one SCCB write per entry, with
// inter-transaction gaps, table DELAY markers, NACK/timeout retry and a
// per-transaction watchdog.
// Ports:
//   XCLK, RST            : clock, synchronous active-high reset
//   init_req             : pulse; starts the sequence when not busy
//   rom_addr / rom_data  : table ROM interface (1 cycle read latency)
//   sccb_start ...       : request side of the SCCB master handshake
//   sccb_done/ack_err    : completion side of the SCCB master handshake
//   PWDN                 : sensor power-down
//   busy, init_done, init_err, err_index : status
module sccb_init_sequencer
  import sccb_pkg::*;
#(
  parameter logic [7:0]  DEVICE_ADDR    = OV2640_WR_ID,
  parameter int unsigned ROM_AW         = 8,
  parameter int unsigned PWDN_CYCLES    = 50000,
  parameter int unsigned WAKE_CYCLES    = 100000,
  parameter int unsigned GAP_CYCLES     = 500,
  parameter int unsigned DELAY_CYCLES   = 500000,
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic              XCLK,
  input  logic              RST,
  input  logic              init_req,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              sccb_start,
  output logic              sccb_rw,
  output logic [7:0]        sccb_ip_addr,
  output logic [7:0]        sccb_sub_addr,
  output logic [7:0]        sccb_data,
  input  logic              sccb_done,
  input  logic              sccb_ack_err,
  output logic              PWDN,
  output logic              busy,
  output logic              init_done,
  output logic              init_err,
  output logic [ROM_AW-1:0] err_index
);

  localparam int unsigned CNT_MAX = max_u(max_u(max_u(PWDN_CYCLES, WAKE_CYCLES),
                                                max_u(GAP_CYCLES, DELAY_CYCLES)),
                                          TIMEOUT_CYCLES);
  localparam int unsigned CW = $clog2(CNT_MAX) + 1;
  localparam int unsigned RW = $clog2(MAX_RETRY + 1) + 1;
  localparam logic [ROM_AW-1:0] LAST_INDEX = '1;

  state_t            state;
  state_t            next_state;
  logic [ROM_AW-1:0] index;
  logic [RW-1:0]     retry;
  logic              redo;

  logic              timer_start;
  logic [CW-1:0]     timer_load;
  logic              timer_expired;

  logic              is_end;
  logic              is_delay;
  logic              xfer_ok;
  logic              xfer_fail;
  logic              can_retry;
  logic              last_entry;

  assign is_end     = (rom_data == TBL_END);
  assign is_delay   = (rom_data == TBL_DELAY);
  assign xfer_ok    = sccb_done && !sccb_ack_err;
  // A done pulse in the same cycle as the watchdog expiring takes priority.
  assign xfer_fail  = sccb_done ? sccb_ack_err : timer_expired;
  assign can_retry  = (retry < RW'(MAX_RETRY));
  assign last_entry = (index == LAST_INDEX);

  // The index only changes outside FETCH, so driving the ROM straight from it
  // presents the address in FETCH and the word arrives in LATCH.
  assign rom_addr     = index;
  assign sccb_rw      = 1'b0;
  assign sccb_ip_addr = DEVICE_ADDR;

  sccb_delay_timer #(.CW(CW)) u_timer (
    .clk     (XCLK),
    .rst     (RST),
    .start   (timer_start),
    .load    (timer_load),
    .expired (timer_expired)
  );

  // State register
  always_ff @(posedge XCLK) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: if (init_req) next_state = ST_PWR;
      ST_PWR:   if (timer_expired) next_state = ST_WAKE;
      ST_WAKE:  if (timer_expired) next_state = ST_FETCH;
      ST_FETCH: next_state = ST_LATCH;
      ST_LATCH: begin
        if (is_end)        next_state = ST_DONE;
        else if (is_delay) next_state = ST_DLY;
        else               next_state = ST_ISSUE;
      end
      ST_ISSUE: next_state = ST_WAIT;
      ST_WAIT: begin
        if (xfer_ok)        next_state = last_entry ? ST_ERROR : ST_GAP;
        else if (xfer_fail) next_state = can_retry ? ST_GAP : ST_ERROR;
      end
      ST_GAP:   if (timer_expired) next_state = redo ? ST_ISSUE : ST_FETCH;
      ST_DLY:   if (timer_expired) next_state = last_entry ? ST_ERROR : ST_FETCH;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Output logic; the timer reloads on every state change so each timed
  // phase counts from its own entry.
  always_comb begin
    sccb_start  = (state == ST_ISSUE);
    busy        = !(state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
    timer_start = (next_state != state);
    case (next_state)
      ST_PWR:  timer_load = CW'(PWDN_CYCLES - 1);
      ST_WAKE: timer_load = CW'(WAKE_CYCLES - 1);
      ST_WAIT: timer_load = CW'(TIMEOUT_CYCLES - 1);
      ST_GAP:  timer_load = CW'(GAP_CYCLES - 1);
      ST_DLY:  timer_load = CW'(DELAY_CYCLES - 1);
      default: timer_load = '0;
    endcase
  end

  // Datapath and status registers
  always_ff @(posedge XCLK) begin
    if (RST) begin
      index         <= '0;
      retry         <= '0;
      redo          <= 1'b0;
      sccb_sub_addr <= '0;
      sccb_data     <= '0;
      PWDN          <= 1'b1;
      init_done     <= 1'b0;
      init_err      <= 1'b0;
      err_index     <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (init_req) begin
            index     <= '0;
            retry     <= '0;
            redo      <= 1'b0;
            PWDN      <= 1'b1;
            init_done <= 1'b0;
            init_err  <= 1'b0;
          end
        end
        ST_PWR: if (timer_expired) PWDN <= 1'b0;
        ST_LATCH: begin
          if (is_end) begin
            init_done <= 1'b1;
          end else if (!is_delay) begin
            sccb_sub_addr <= rom_data[15:8];
            sccb_data     <= rom_data[7:0];
            retry         <= '0;
            redo          <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (xfer_ok) begin
            redo <= 1'b0;
            if (last_entry) begin
              err_index <= index;
              init_err  <= 1'b1;
            end else begin
              index <= index + ROM_AW'(1);
            end
          end else if (xfer_fail) begin
            if (can_retry) begin
              retry <= retry + RW'(1);
              redo  <= 1'b1;
            end else begin
              err_index <= index;
              init_err  <= 1'b1;
            end
          end
        end
        ST_DLY: begin
          if (timer_expired) begin
            if (last_entry) begin
              err_index <= index;
              init_err  <= 1'b1;
            end else begin
              index <= index + ROM_AW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sccb_init_sequencer.md
Name: sccb_init_sequencer

Overview:
- Drives camera (OV2640-class) register initialisation over the SCCB master core.
- Walks a register table ({sub_addr, data} words) from an external synchronous ROM and issues one SCCB write per entry.
- Also owns the sensor PWDN power-up timing, inter-transaction gaps, table-embedded delays, ACK-error retry and a transaction watchdog.
- Sits between the system control logic (init request/status) and the SCCB master (start/done handshake).

Parameters:
- DEVICE_ADDR, 8'h60, SCCB write ID driven on sccb_ip_addr.
- ROM_AW, 8, ROM address width; table holds at most 2^ROM_AW entries.
- PWDN_CYCLES, 50000, XCLK cycles PWDN is held high after a request.
- WAKE_CYCLES, 100000, XCLK cycles waited after PWDN falls, before the first transaction.
- GAP_CYCLES, 500, idle XCLK cycles between consecutive SCCB transactions.
- DELAY_CYCLES, 500000, wait length for a table DELAY marker.
- TIMEOUT_CYCLES, 200000, maximum cycles from sccb_start to sccb_done.
- MAX_RETRY, 3, retries per entry on ACK error or timeout.

Ports:
- XCLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- init_req  in  1  single-cycle pulse; starts (or restarts) the init sequence.
- rom_addr  out  ROM_AW  table address.
- rom_data  in  16  table word {sub_addr[15:8], data[7:0]}; valid 1 cycle after rom_addr.
- sccb_start  out  1  single-cycle transaction request to the SCCB master.
- sccb_rw  out  1  always 0 (write).
- sccb_ip_addr  out  8  DEVICE_ADDR.
- sccb_sub_addr  out  8  register address, stable from sccb_start until sccb_done.
- sccb_data  out  8  register data, stable from sccb_start until sccb_done.
- sccb_done  in  1  single-cycle completion pulse from the master.
- sccb_ack_err  in  1  qualified by sccb_done; 1 = slave NACK.
- PWDN  out  1  sensor power-down.
- busy  out  1  high in every state except IDLE, DONE and ERROR.
- init_done  out  1  sticky; set on reaching DONE.
- init_err  out  1  sticky; set on reaching ERROR.
- err_index  out  ROM_AW  table index of the failing entry.

Behaviour:
- Reset values: state=IDLE, rom_addr=0, sccb_start=0, sccb_sub_addr=0, sccb_data=0, PWDN=1, busy=0, init_done=0, init_err=0, err_index=0, all counters and retry count 0.
- Table encoding: 16'hFFFF = END; 16'hFFFE = DELAY marker; any other word = write entry.
- States and transitions:
  - IDLE/DONE/ERROR: on init_req, go to PWR. Entering PWR clears init_done, init_err and the index, and sets PWDN=1.
  - PWR: count PWDN_CYCLES, then PWDN<=0 and go to WAKE.
  - WAKE: count WAKE_CYCLES, then go to FETCH.
  - FETCH: drive rom_addr=index, then go to LATCH (1 cycle of ROM latency).
  - LATCH: decode rom_data.
    - END: go to DONE.
    - DELAY: go to DLY.
    - Otherwise latch sub_addr/data into the outputs, clear the retry count, go to ISSUE.
  - ISSUE: assert sccb_start for exactly 1 cycle, go to WAIT.
  - WAIT: run the watchdog.
    - sccb_done with ack_err=0: index++, go to GAP.
    - sccb_done with ack_err=1, or watchdog reaches TIMEOUT_CYCLES: if retry<MAX_RETRY, retry++ and go to GAP, then re-ISSUE the same entry (no refetch). Otherwise err_index<=index and go to ERROR.
  - GAP: count GAP_CYCLES, then go to ISSUE (retry) or FETCH (next entry).
  - DLY: count DELAY_CYCLES, index++, go to FETCH.
- Latency: the first sccb_start occurs exactly PWDN_CYCLES+WAKE_CYCLES+3 cycles after the init_req cycle.
- Index wrap: if index overflows past 2^ROM_AW-1 without seeing END, go to ERROR with err_index = all ones. The table is never read past its end.
- init_req while busy: ignored. It never aborts a transaction in flight.
- sccb_done outside WAIT: ignored.
- sccb_done and timeout in the same cycle: sccb_done wins.
- RST mid-operation: immediately returns to the reset values, and PWDN goes to 1 (sensor powered down).
- Counters: sized $clog2(max parameter)+1. Each counter loads 0 on state entry and terminates at (param-1), giving exactly param cycles in-state.

Decomposition:
- Shared package sccb_pkg holds:
  - state enum;
  - table markers TBL_END=16'hFFFF and TBL_DELAY=16'hFFFE;
  - OV2640 write/read IDs 8'h60/8'h61.
- One sub-module, sccb_delay_timer: a loadable down-counter with start/expired, shared by PWR, WAKE, GAP, DLY and the watchdog (only one is active at a time).

Test Plan:
- Normal run (small params PWDN=4, WAKE=8, GAP=2; table {0x12_80, 0x11_01, 0xFFFF}; model returns ack_err=0 after 20 cycles) -> PWDN high 4 cycles; first sccb_start 15 cycles after init_req; two starts with sub/data 12/80 then 11/01; starts separated by ≥2 idle cycles after done; init_done=1, busy=0, rom_addr never exceeds 2.
- NACK recovery (entry 0x12_80; first two dones carry ack_err=1, third is clean) -> three sccb_start pulses, all with 12/80; init_done=1, init_err=0.
- Persistent NACK (MAX_RETRY=3, ack_err always 1) -> exactly 4 starts; init_err=1; err_index=0; PWDN stays 0.
- Watchdog (TIMEOUT=50, model never raises done) -> restart after 50 cycles; after the 4th timeout init_err=1.
- DELAY marker (table {0x12_80, 0xFFFE, 0x11_01, 0xFFFF}, DELAY=30) -> gap between done of entry 0 and start of entry 2 ≥ GAP+30+2 cycles.
- Reset mid-WAIT (assert RST while a transaction is pending) -> next cycle busy=0, PWDN=1, sccb_start=0; a later init_req restarts from index 0.
